// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default widths for the instruction fetch unit
package fetch_pkg;

  localparam int DEF_PC_W    = 8;
  localparam int DEF_INST_W  = 9;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with redirect and halt; optional FETCH_STALL_CNT_EN stall counter
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int INST_W   = DEF_INST_W,
  parameter int RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rdy,
  input  logic [INST_W-1:0] imem_data,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              halt_req,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              dec_ready,
  output logic              halted
`ifdef FETCH_STALL_CNT_EN
  , output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_t      state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic [PC_W-1:0]   addr_nxt;
  logic              req_nxt;
  logic              valid_nxt;
  logic [INST_W-1:0] inst_nxt;
  logic [PC_W-1:0]   inst_pc_nxt;
  logic              halted_nxt;
  logic              redirect;
  logic              transfer;

  // A redirect only matters while actively fetching or holding; HALTED ignores it.
  // The redirect beats a same-cycle handshake, so a transfer requires !br_taken.
  assign redirect = br_taken && ((state == ST_FETCH) || (state == ST_HOLD));
  assign transfer = (state == ST_HOLD) && inst_valid && dec_ready && !br_taken;

  // State and every output are registered; reset abandons any in-flight instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pc         <= RST_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RST_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      imem_req   <= req_nxt;
      imem_addr  <= addr_nxt;
      inst_valid <= valid_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
      halted     <= halted_nxt;
    end
  end

  // Next-state selection: redirect first, then halt, then the memory/decode handshakes.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (br_taken)      state_nxt = ST_FETCH;
        else if (halt_req) state_nxt = ST_HALTED;
        else if (imem_rdy) state_nxt = ST_HOLD;
        else               state_nxt = ST_FETCH;
      end
      ST_HOLD: begin
        if (br_taken)      state_nxt = ST_FETCH;
        else if (transfer) state_nxt = halt_req ? ST_HALTED : ST_FETCH;
        else               state_nxt = ST_HOLD;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and pc; anything not touched holds.
  always_comb begin
    pc_nxt      = pc;
    addr_nxt    = imem_addr;
    req_nxt     = imem_req;
    valid_nxt   = inst_valid;
    inst_nxt    = inst;
    inst_pc_nxt = inst_pc;
    halted_nxt  = halted;
    if (redirect) begin
      // Any data returned this cycle belongs to the wrong path and is dropped.
      pc_nxt    = br_target;
      addr_nxt  = br_target;
      req_nxt   = 1'b1;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_nxt  = 1'b1;
          addr_nxt = pc;
        end
        ST_FETCH: begin
          if (halt_req) begin
            req_nxt    = 1'b0;
            valid_nxt  = 1'b0;
            halted_nxt = 1'b1;
          end else if (imem_rdy) begin
            inst_nxt    = imem_data;
            inst_pc_nxt = pc;
            valid_nxt   = 1'b1;
            pc_nxt      = pc + PC_ONE;
            req_nxt     = 1'b0;
          end
        end
        ST_HOLD: begin
          if (transfer) begin
            valid_nxt = 1'b0;
            if (halt_req) begin
              halted_nxt = 1'b1;
            end else begin
              req_nxt  = 1'b1;
              addr_nxt = pc;
            end
          end
        end
        ST_HALTED: begin
          req_nxt    = 1'b0;
          valid_nxt  = 1'b0;
          halted_nxt = 1'b1;
        end
        default: begin
          req_nxt   = 1'b0;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  // Count FETCH cycles spent waiting on memory, saturating rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == ST_FETCH) && !imem_rdy && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule
